// File: rtl/mcycle_pipe_ctrl.sv
// Sequencer for the multi-cycle MUL/DIV unit: issues start pulses, holds F/D/E
// for the whole operation, and arbitrates DE-register enable/clear against load-use stalls and flushes.
module mcycle_pipe_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          MCycleOpE,
  input  logic          CondExE,
  input  logic          MSE,
  input  logic          MCDone,
  input  logic          LdUseHazard,
  input  logic          PCSrcE,
  output logic          StallF,
  output logic          StallD,
  output logic          EnDE,
  output logic          FlushD,
  output logic          FlushE,
  output logic          MCStart,
  output logic          MCOp,
  output logic          MCResSelE,
  output logic          MCBusy,
  output logic          MCErr,
  output logic [CW-1:0] CycCnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic          mc_op_q, mc_op_d;
  logic          mc_err_q, mc_err_d;
  logic          mc_req;
  logic          timeout_hit;

  assign mc_req      = MCycleOpE & CondExE;
  assign timeout_hit = (cyc_cnt_q == TIMEOUT_LAST);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cyc_cnt_q <= '0;
      mc_op_q   <= 1'b0;
      mc_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_cnt_q <= cyc_cnt_d;
      mc_op_q   <= mc_op_d;
      mc_err_q  <= mc_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cyc_cnt_d = cyc_cnt_q;
    mc_op_d   = mc_op_q;
    mc_err_d  = mc_err_q;
    StallF    = 1'b0;
    StallD    = 1'b0;
    EnDE      = 1'b1;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    MCStart   = 1'b0;
    MCResSelE = 1'b0;
    MCBusy    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mc_req) begin
          // The request owns the pipeline: any flush is dropped so the op stays in E.
          MCStart   = ~Reset;
          StallF    = 1'b1;
          StallD    = 1'b1;
          EnDE      = 1'b0;
          mc_op_d   = MSE;
          cyc_cnt_d = '0;
          state_d   = S_WAIT;
        end else begin
          StallF = LdUseHazard;
          StallD = LdUseHazard;
          FlushD = PCSrcE;
          FlushE = LdUseHazard | PCSrcE;
        end
      end
      S_WAIT: begin
        StallF    = 1'b1;
        StallD    = 1'b1;
        EnDE      = 1'b0;
        MCBusy    = 1'b1;
        cyc_cnt_d = cyc_cnt_q + CW'(1);
        if (MCDone) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          mc_err_d = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        // The finishing op is still in E, so a new request cannot start here.
        MCResSelE = 1'b1;
        StallF    = LdUseHazard;
        StallD    = LdUseHazard;
        FlushD    = PCSrcE;
        FlushE    = LdUseHazard | PCSrcE;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign MCOp   = mc_op_q;
  assign MCErr  = mc_err_q;
  assign CycCnt = cyc_cnt_q;

endmodule

// File: tb/tb_mcycle_pipe_ctrl.sv
// Directed bench for mcycle_pipe_ctrl; outputs packed as
// {StallF,StallD,EnDE,FlushD,FlushE,MCStart,MCResSelE,MCBusy}.
module tb_mcycle_pipe_ctrl;

  localparam int TIMEOUT = 64;
  localparam int CW      = 7;

  localparam logic [7:0] O_IDLE  = 8'b0010_0000;
  localparam logic [7:0] O_START = 8'b1100_0100;
  localparam logic [7:0] O_WAIT  = 8'b1100_0001;
  localparam logic [7:0] O_DONE  = 8'b0010_0010;

  logic          CLK = 1'b0;
  logic          Reset = 1'b0;
  logic          MCycleOpE = 1'b0, CondExE = 1'b0, MSE = 1'b0, MCDone = 1'b0;
  logic          LdUseHazard = 1'b0, PCSrcE = 1'b0;
  logic          StallF, StallD, EnDE, FlushD, FlushE, MCStart, MCOp;
  logic          MCResSelE, MCBusy, MCErr;
  logic [CW-1:0] CycCnt;
  logic [7:0]    outs;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  assign outs = {StallF, StallD, EnDE, FlushD, FlushE, MCStart, MCResSelE, MCBusy};

  mcycle_pipe_ctrl #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .CLK(CLK), .Reset(Reset), .MCycleOpE(MCycleOpE), .CondExE(CondExE), .MSE(MSE),
    .MCDone(MCDone), .LdUseHazard(LdUseHazard), .PCSrcE(PCSrcE),
    .StallF(StallF), .StallD(StallD), .EnDE(EnDE), .FlushD(FlushD), .FlushE(FlushE),
    .MCStart(MCStart), .MCOp(MCOp), .MCResSelE(MCResSelE), .MCBusy(MCBusy),
    .MCErr(MCErr), .CycCnt(CycCnt)
  );

  // Advance to just after the next rising edge, apply inputs, let logic settle.
  task automatic cyc(input logic op, input logic cond, input logic mse,
                     input logic done, input logic lu, input logic pc);
    @(posedge CLK);
    #1;
    MCycleOpE = op; CondExE = cond; MSE = mse; MCDone = done; LdUseHazard = lu; PCSrcE = pc;
    #2;
  endtask

  task automatic test_reset;
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (outs !== O_IDLE || CycCnt !== '0 || MCOp !== 1'b0 || MCErr !== 1'b0) begin
      failures++;
      $display("FAIL reset_state outs=%b cyc=%0d op=%b err=%b required outs=%b cyc=0 op=0 err=0",
               outs, CycCnt, MCOp, MCErr, O_IDLE);
    end
    cyc(1, 1, 1, 0, 0, 0);
    checks++;
    if (MCStart !== 1'b0) begin
      failures++;
      $display("FAIL reset_gates_start MCStart=%b required 0", MCStart);
    end
    cyc(0, 0, 0, 0, 0, 0);
    Reset = 1'b0;
    #1;
    checks++;
    if (outs !== O_IDLE || CycCnt !== '0) begin
      failures++;
      $display("FAIL reset_release outs=%b cyc=%0d required %b cyc=0", outs, CycCnt, O_IDLE);
    end
    $display("txn reset: done");
  endtask

  task automatic test_mul_div;
    cyc(1, 1, 1, 0, 0, 0);
    checks++;
    if (outs !== O_START) begin
      failures++;
      $display("FAIL div_start outs=%b required %b", outs, O_START);
    end
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 1, 0, (k == 5), 0, 0);
      checks++;
      if (outs !== O_WAIT || CycCnt !== CW'(k - 1) || MCOp !== 1'b1) begin
        failures++;
        $display("FAIL div_wait%0d outs=%b cyc=%0d op=%b required %b cyc=%0d op=1",
                 k, outs, CycCnt, MCOp, O_WAIT, k - 1);
      end
    end
    cyc(1, 1, 0, 0, 0, 0);
    checks++;
    if (outs !== O_DONE) begin
      failures++;
      $display("FAIL div_done outs=%b required %b", outs, O_DONE);
    end
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (outs !== O_IDLE || MCErr !== 1'b0) begin
      failures++;
      $display("FAIL div_idle outs=%b err=%b required %b err=0", outs, MCErr, O_IDLE);
    end
    $display("txn div: start, 5 wait cycles, done, idle");
  endtask

  task automatic test_cond_fail;
    cyc(1, 0, 1, 0, 0, 0);
    checks++;
    if (outs !== O_IDLE) begin
      failures++;
      $display("FAIL cond_fail outs=%b required %b", outs, O_IDLE);
    end
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (outs !== O_IDLE) begin
      failures++;
      $display("FAIL cond_fail_next outs=%b required %b", outs, O_IDLE);
    end
    $display("txn cond_fail: no start");
  endtask

  task automatic test_hazards;
    cyc(0, 0, 0, 0, 1, 0);
    checks++;
    if (outs !== 8'b1110_1000) begin
      failures++;
      $display("FAIL idle_lduse outs=%b required %b", outs, 8'b1110_1000);
    end
    cyc(0, 0, 0, 0, 0, 1);
    checks++;
    if (outs !== 8'b0011_1000) begin
      failures++;
      $display("FAIL idle_branch outs=%b required %b", outs, 8'b0011_1000);
    end
    cyc(0, 0, 0, 0, 1, 1);
    checks++;
    if (outs !== 8'b1111_1000) begin
      failures++;
      $display("FAIL idle_both outs=%b required %b", outs, 8'b1111_1000);
    end
    cyc(1, 1, 0, 0, 0, 1);
    checks++;
    if (outs !== O_START) begin
      failures++;
      $display("FAIL req_beats_branch outs=%b required %b", outs, O_START);
    end
    cyc(1, 1, 0, 0, 1, 1);
    checks++;
    if (outs !== O_WAIT || MCOp !== 1'b0) begin
      failures++;
      $display("FAIL wait_masked outs=%b op=%b required %b op=0", outs, MCOp, O_WAIT);
    end
    cyc(1, 1, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 1);
    checks++;
    if (outs !== 8'b0011_1010) begin
      failures++;
      $display("FAIL done_branch outs=%b required %b", outs, 8'b0011_1010);
    end
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (outs !== O_IDLE) begin
      failures++;
      $display("FAIL hazard_idle outs=%b required %b", outs, O_IDLE);
    end
    $display("txn hazards: idle lduse/branch/both, masked in wait, branch in done");
  endtask

  task automatic test_timeout;
    cyc(1, 1, 0, 0, 0, 0);
    checks++;
    if (outs !== O_START) begin
      failures++;
      $display("FAIL to_start outs=%b required %b", outs, O_START);
    end
    for (int k = 1; k <= TIMEOUT; k++) begin
      cyc(1, 1, 0, 0, 0, 0);
      checks++;
      if (outs !== O_WAIT || CycCnt !== CW'(k - 1) || MCErr !== 1'b0) begin
        failures++;
        $display("FAIL to_wait%0d outs=%b cyc=%0d err=%b required %b cyc=%0d err=0",
                 k, outs, CycCnt, MCErr, O_WAIT, k - 1);
      end
    end
    cyc(1, 1, 0, 0, 0, 0);
    checks++;
    if (outs !== O_DONE || MCErr !== 1'b1) begin
      failures++;
      $display("FAIL to_done outs=%b err=%b required %b err=1", outs, MCErr, O_DONE);
    end
    $display("txn timeout: done after %0d wait cycles", TIMEOUT);
  endtask

  task automatic test_back_to_back;
    // New request right after DONE, with a stray MCDone in the start cycle.
    cyc(1, 1, 1, 1, 0, 0);
    checks++;
    if (outs !== O_START) begin
      failures++;
      $display("FAIL b2b_start outs=%b required %b", outs, O_START);
    end
    cyc(1, 1, 0, 0, 0, 0);
    checks++;
    if (outs !== O_WAIT || MCOp !== 1'b1 || CycCnt !== '0) begin
      failures++;
      $display("FAIL b2b_wait outs=%b op=%b cyc=%0d required %b op=1 cyc=0", outs, MCOp, CycCnt, O_WAIT);
    end
    cyc(1, 1, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    checks++;
    if (outs !== O_DONE || MCErr !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done outs=%b err=%b required %b err=1", outs, MCErr, O_DONE);
    end
    cyc(0, 0, 0, 0, 0, 0);
    $display("txn back_to_back: start ignores same-cycle MCDone, err sticky");
  endtask

  task automatic test_reset_in_wait;
    int res_pulses;
    res_pulses = 0;
    cyc(1, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    Reset = 1'b1;
    #1;
    checks++;
    if (outs !== O_IDLE || MCErr !== 1'b0 || CycCnt !== '0 || MCOp !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset outs=%b err=%b cyc=%0d op=%b required %b err=0 cyc=0 op=0",
               outs, MCErr, CycCnt, MCOp, O_IDLE);
    end
    cyc(0, 0, 0, 0, 0, 0);
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (MCResSelE !== 1'b0 || MCBusy !== 1'b0) res_pulses++;
    end
    checks++;
    if (res_pulses !== 0) begin
      failures++;
      $display("FAIL abort_no_result busy_or_res_cycles=%0d required 0", res_pulses);
    end
    cyc(1, 1, 0, 0, 0, 0);
    checks++;
    if (outs !== O_START) begin
      failures++;
      $display("FAIL restart outs=%b required %b", outs, O_START);
    end
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (outs !== O_DONE || MCOp !== 1'b0) begin
      failures++;
      $display("FAIL restart_done outs=%b op=%b required %b op=0", outs, MCOp, O_DONE);
    end
    $display("txn reset_in_wait: aborted, restart completes");
  endtask

  initial begin
    test_reset;
    test_mul_div;
    test_cond_fail;
    test_hazards;
    test_timeout;
    test_back_to_back;
    test_reset_in_wait;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcycle_pipe_ctrl.md
# mcycle_pipe_ctrl

Pipeline sequencer for the multi-cycle (MUL/DIV) unit and the decode/execute boundary. It issues start pulses to the MCycle unit and holds Fetch, Decode and Execute for the full multi-cycle operation. It also generates the enable and clear controls for the DE pipeline register, merging MCycle stalls with load-use stalls and branch flushes under a fixed priority. A watchdog counter bounds every MCycle operation.

## Interface
Parameters
- TIMEOUT, 64: maximum cycles spent in WAIT before a forced completion.
- CW, 7: width of the cycle counter; must satisfy 2^CW > TIMEOUT.

Ports
- CLK  in  1  clock.
- Reset  in  1  asynchronous, active-high reset.
- MCycleOpE  in  1  the instruction in E is a multi-cycle op.
- CondExE  in  1  the condition check passed for the instruction in E.
- MSE  in  1  operation select latched at start: 0 = multiply, 1 = divide.
- MCDone  in  1  the MCycle unit has finished; result valid this cycle.
- LdUseHazard  in  1  load-use hazard between D and E.
- PCSrcE  in  1  branch/PC write taken in E.
- StallF  out  1  hold the PC.
- StallD  out  1  hold the FD register.
- EnDE  out  1  EN of the DE register.
- FlushD  out  1  clear the FD register.
- FlushE  out  1  CLR of the DE register.
- MCStart  out  1  one-cycle start pulse to the MCycle unit.
- MCOp  out  1  registered MSE at start.
- MCResSelE  out  1  select the MCycle result in the E writeback mux.
- MCBusy  out  1  an operation is in flight.
- MCErr  out  1  sticky flag: a timeout occurred.
- CycCnt  out  CW  cycles elapsed in the current WAIT.

## Operation
- McReq = MCycleOpE & CondExE.
- The FSM has three states: IDLE, WAIT, DONE.
- IDLE:
  - On McReq: MCStart=1, MCOp<=MSE, CycCnt<=0. Assert StallF, StallD, EnDE=0. Next state WAIT.
  - Otherwise, on LdUseHazard: StallF=1, StallD=1, FlushE=1, EnDE=1.
  - On PCSrcE: FlushD=1, FlushE=1.
  - LdUseHazard and PCSrcE together: both apply (StallF, StallD, FlushD, FlushE all 1).
- WAIT:
  - StallF=1, StallD=1, EnDE=0, MCBusy=1. CycCnt increments each cycle.
  - LdUseHazard and PCSrcE are masked.
  - MCDone, or CycCnt==TIMEOUT-1 → DONE. A timeout also sets MCErr.
- DONE, exactly one cycle:
  - MCResSelE=1. All stalls released, EnDE=1, MCBusy=0. Next state IDLE.
  - McReq is ignored in DONE, because the completing op is still in E.
  - PCSrcE/LdUseHazard are handled as in IDLE.
- McReq with PCSrcE in IDLE: McReq wins and the flushes are suppressed. A PC-destination MCycle op is unsupported.
- MCDone in the same cycle as MCStart is ignored; MCDone in IDLE or DONE is ignored.
- FlushE is never asserted while EnDE=0.
- MCErr clears only on Reset.

## Timing
- Reset (async): state IDLE, CycCnt=0, MCOp=0, MCErr=0.
  - MCStart is gated to 0 while Reset is high.
  - With all inputs low, every output is 0 except EnDE=1.
- The stall/flush/enable outputs are combinational from state and inputs, in the same cycle; MCStart is combinational from IDLE and McReq.
- Latency: a request in cycle t gives MCStart at t and WAIT from t+1. MCDone at cycle d (d>t) gives DONE at d+1 and new DE contents at d+2.
- Pipeline hold is (d-t)+2 cycles, counting the request and DONE cycles.
- With MCDone never asserted: the request at t, timeout exit at t+TIMEOUT, DONE at t+TIMEOUT+1.
- A Reset during WAIT aborts the operation. No MCResSelE is produced, and the pipeline resumes in IDLE.

## Test plan
- Reset then idle inputs → all outputs 0, EnDE=1, CycCnt=0.
- MCycleOpE=1, CondExE=1, MSE=1 at t0; MCDone at t0+5 → MCStart only at t0, MCOp=1, stalls high t0..t0+5, MCResSelE=1 at t0+6, EnDE=1 at t0+6, IDLE at t0+7.
- MCycleOpE=1, CondExE=0 → no MCStart, no stall, EnDE=1.
- LdUseHazard=1 in IDLE → StallF=StallD=FlushE=1, EnDE=1; the same input during WAIT → FlushE=0, EnDE=0.
- MCDone never asserted, TIMEOUT=64 → DONE 64 cycles after WAIT entry, MCErr=1 and held through the following operations until Reset.
- Reset asserted at the third WAIT cycle → state IDLE immediately, MCBusy=0, MCResSelE never pulses; a new request after reset starts normally.
